dual_toggle_gen: RTL

//  Cycle-accurate stimulus source for the SVA lecture benches. Drives two square waves, a and b,

---
 rtl/dtg_pkg.sv | 13 +
 rtl/toggle_chan.sv | 34 +++
 rtl/dual_toggle_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/dtg_pkg.sv
// Shared types and default widths for the dual toggle generator.
package dtg_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int RUN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dtg_state_e;

endpackage

// File: rtl/toggle_chan.sv
// One square-wave channel: toggles q every hp enabled edges.
// hp must be nonzero; the top level maps a programmed 0 to 1.
module toggle_chan #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] hp,
    output logic             q
);

    logic [CNT_W-1:0] cnt;

    // Half-period counter and output flop; clear has priority over en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (en) begin
            if (cnt == hp - CNT_W'(1)) begin
                cnt <= '0;
                q   <= ~q;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dual_toggle_gen.sv
// Two independently programmed square waves with bounded or free runs.
// Holds the run FSM, the latched run parameters and the run cycle counter.
module dual_toggle_gen
    import dtg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] half_per_a,
    input  logic [CNT_W-1:0] half_per_b,
    input  logic [RUN_W-1:0] run_len,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] cycle_cnt
);

    localparam int NUM_CH = 2;

    dtg_state_e                    state;
    logic [NUM_CH-1:0][CNT_W-1:0]  hp_in;
    logic [NUM_CH-1:0][CNT_W-1:0]  hp_q;
    logic [NUM_CH-1:0]             chan_q;
    logic [RUN_W-1:0]              run_len_q;
    logic                          start_acc;
    logic                          last_edge;
    logic                          in_run;

    assign hp_in[0] = half_per_a;
    assign hp_in[1] = half_per_b;

    assign in_run    = (state == RUN);
    // Stop beats start; start while running is ignored.
    assign start_acc = start && !stop && !in_run;
    // Edge E0+run_len of a bounded run: the counter is one short of run_len.
    assign last_edge = in_run && (run_len_q != '0) &&
                       (cycle_cnt == run_len_q - RUN_W'(1));

    // Run FSM: stop always returns to IDLE, even on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (stop) begin
            state <= IDLE;
        end else if (start_acc) begin
            state <= RUN;
        end else if (last_edge) begin
            state <= DONE;
        end
    end

    // Parameter latches; a zero half-period would never toggle, so use 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q      <= '0;
            run_len_q <= '0;
        end else if (start_acc) begin
            for (int i = 0; i < NUM_CH; i++)
                hp_q[i] <= (hp_in[i] == '0) ? CNT_W'(1) : hp_in[i];
            run_len_q <= run_len;
        end
    end

    // Run cycle counter: cleared at start, counts every RUN edge (including
    // the stop edge), saturates at all-ones, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (start_acc) begin
            cycle_cnt <= '0;
        end else if (in_run && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + RUN_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        toggle_chan #(.CNT_W(CNT_W)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (stop || start_acc),
            .en    (in_run),
            .hp    (hp_q[g]),
            .q     (chan_q[g])
        );
    end

    assign a    = chan_q[0];
    assign b    = chan_q[1];
    assign busy = in_run;
    assign done = (state == DONE);

endmodule
